// File: rtl/demux_2_stream.sv
// demux_2_stream: routes one valid/ready input stream into two buffered output channels (a, b).
// Define DEMUX_2_STREAM_CNT_EN to enable the per-channel completed-transfer counters.
module demux_2_stream #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [DATA_W-1:0] a_data,
    output logic              a_valid,
    input  logic              a_ready,
    output logic [DATA_W-1:0] b_data,
    output logic              b_valid,
    input  logic              b_ready,
    output logic [15:0]       a_cnt,
    output logic [15:0]       b_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int OCC_W = $clog2(DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

    // Index 0 is channel a, index 1 is channel b.
    logic [DATA_W-1:0] r_mem    [2][DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr [2];
    logic [PTR_W-1:0]  r_rd_ptr [2];
    logic [OCC_W-1:0]  r_occ    [2];

    logic [1:0] w_full;
    logic [1:0] w_push;
    logic [1:0] w_pop;
    logic [1:0] w_out_ready;

    assign w_out_ready = {b_ready, a_ready};

    always_comb begin
        w_full = '0;
        w_pop  = '0;
        for (int c = 0; c < 2; c++) begin
            w_full[c] = (r_occ[c] == OCC_FULL);
            w_pop[c]  = (r_occ[c] != '0) && w_out_ready[c];
        end
    end

    // Full means no accept, even if that buffer pops this same cycle.
    assign in_ready  = in_sel ? ~w_full[1] : ~w_full[0];
    assign w_push[0] = in_valid && !in_sel && !w_full[0];
    assign w_push[1] = in_valid &&  in_sel && !w_full[1];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int c = 0; c < 2; c++) begin
                for (int e = 0; e < DEPTH; e++) begin
                    r_mem[c][e] <= '0;
                end
                r_wr_ptr[c] <= '0;
                r_rd_ptr[c] <= '0;
                r_occ[c]    <= '0;
            end
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (w_push[c]) begin
                    r_mem[c][r_wr_ptr[c]] <= in_data;
                    r_wr_ptr[c] <= (r_wr_ptr[c] == PTR_LAST) ? '0 : r_wr_ptr[c] + 1'b1;
                end
                if (w_pop[c]) begin
                    r_rd_ptr[c] <= (r_rd_ptr[c] == PTR_LAST) ? '0 : r_rd_ptr[c] + 1'b1;
                end
                case ({w_push[c], w_pop[c]})
                    2'b10:   r_occ[c] <= r_occ[c] + 1'b1;
                    2'b01:   r_occ[c] <= r_occ[c] - 1'b1;
                    default: r_occ[c] <= r_occ[c];
                endcase
            end
        end
    end

    assign a_data  = r_mem[0][r_rd_ptr[0]];
    assign b_data  = r_mem[1][r_rd_ptr[1]];
    assign a_valid = (r_occ[0] != '0);
    assign b_valid = (r_occ[1] != '0);

`ifdef DEMUX_2_STREAM_CNT_EN
    logic [15:0] r_cnt [2];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt[0] <= '0;
            r_cnt[1] <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (w_pop[c]) begin
                    r_cnt[c] <= r_cnt[c] + 16'd1;
                end
            end
        end
    end

    assign a_cnt = r_cnt[0];
    assign b_cnt = r_cnt[1];
`else
    assign a_cnt = '0;
    assign b_cnt = '0;
`endif

endmodule

// File: tb/tb_demux_2_stream.sv
// Directed + random bench for demux_2_stream with a per-channel scoreboard.
// Counter expectations follow DEMUX_2_STREAM_CNT_EN.
module tb_demux_2_stream;

    localparam int DATA_W = 8;
`ifdef DEMUX_2_STREAM_CNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst;
    logic [DATA_W-1:0] in_data;
    logic              in_sel;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] a_data;
    logic              a_valid;
    logic              a_ready;
    logic [DATA_W-1:0] b_data;
    logic              b_valid;
    logic              b_ready;
    logic [15:0]       a_cnt;
    logic [15:0]       b_cnt;

    int checks   = 0;
    int failures = 0;

    logic [DATA_W-1:0] q_a [$];
    logic [DATA_W-1:0] q_b [$];
    logic [15:0]       m_a_cnt = '0;
    logic [15:0]       m_b_cnt = '0;

    demux_2_stream #(.DATA_W(DATA_W), .DEPTH(2)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_data  (in_data),
        .in_sel   (in_sel),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a_data   (a_data),
        .a_valid  (a_valid),
        .a_ready  (a_ready),
        .b_data   (b_data),
        .b_valid  (b_valid),
        .b_ready  (b_ready),
        .a_cnt    (a_cnt),
        .b_cnt    (b_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: sample at the falling edge, i.e. what the next rising edge will commit.
    always @(negedge clk) begin
        if (rst) begin
            q_a.delete();
            q_b.delete();
            m_a_cnt = '0;
            m_b_cnt = '0;
            chk("rst_a_valid", 32'(a_valid), 32'd0);
            chk("rst_b_valid", 32'(b_valid), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd1);
        end else begin
            chk("sb_a_valid", 32'(a_valid), 32'(q_a.size() != 0));
            chk("sb_b_valid", 32'(b_valid), 32'(q_b.size() != 0));
            if (a_valid && q_a.size() != 0) chk("sb_a_data", 32'(a_data), 32'(q_a[0]));
            if (b_valid && q_b.size() != 0) chk("sb_b_data", 32'(b_data), 32'(q_b[0]));
            chk("sb_a_cnt", 32'(a_cnt), CNT_EN ? 32'(m_a_cnt) : 32'd0);
            chk("sb_b_cnt", 32'(b_cnt), CNT_EN ? 32'(m_b_cnt) : 32'd0);
            if (a_valid && a_ready && q_a.size() != 0) begin
                void'(q_a.pop_front());
                m_a_cnt = m_a_cnt + 16'd1;
            end
            if (b_valid && b_ready && q_b.size() != 0) begin
                void'(q_b.pop_front());
                m_b_cnt = m_b_cnt + 16'd1;
            end
            if (in_valid && in_ready) begin
                if (in_sel) q_b.push_back(in_data);
                else        q_a.push_back(in_data);
            end
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
        a_ready = 1'b0; b_ready = 1'b0;
        #2;
        chk("reset_a_valid", 32'(a_valid), 32'd0);
        chk("reset_b_valid", 32'(b_valid), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        chk("reset_a_data", 32'(a_data), 32'd0);
        chk("reset_b_data", 32'(b_data), 32'd0);
        chk("reset_a_cnt", 32'(a_cnt), 32'd0);
        chk("reset_b_cnt", 32'(b_cnt), 32'd0);
        cyc(); cyc();
        rst = 1'b0;

        // Routing
        a_ready = 1'b1; b_ready = 1'b1;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'hA5; #1;
        chk("route_in_ready_a", 32'(in_ready), 32'd1);
        cyc();
        in_sel = 1'b1; in_data = 8'h3C; #1;
        chk("route_a_valid", 32'(a_valid), 32'd1);
        chk("route_a_data", 32'(a_data), 32'hA5);
        chk("route_b_empty", 32'(b_valid), 32'd0);
        cyc();
        in_valid = 1'b0; #1;
        chk("route_b_valid", 32'(b_valid), 32'd1);
        chk("route_b_data", 32'(b_data), 32'h3C);
        chk("route_a_drained", 32'(a_valid), 32'd0);
        cyc();

        // Backpressure / full
        a_ready = 1'b0;
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h11; #1;
        chk("bp_accept_11", 32'(in_ready), 32'd1);
        cyc();
        in_data = 8'h22; #1;
        chk("bp_accept_22", 32'(in_ready), 32'd1);
        chk("bp_head_11", 32'(a_data), 32'h11);
        cyc();
        in_data = 8'h33; #1;
        chk("bp_full_33", 32'(in_ready), 32'd0);
        cyc();
        chk("bp_full_hold", 32'(in_ready), 32'd0);
        chk("bp_head_hold", 32'(a_data), 32'h11);

        // Channel independence while a is full
        in_sel = 1'b1; in_data = 8'h44; #1;
        chk("indep_in_ready_b", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0; #1;
        chk("indep_b_valid", 32'(b_valid), 32'd1);
        chk("indep_b_data", 32'(b_data), 32'h44);
        chk("indep_a_hold", 32'(a_data), 32'h11);
        chk("indep_a_valid", 32'(a_valid), 32'd1);
        cyc();

        // Full with pop in the same cycle: no bypass
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h33; a_ready = 1'b1; #1;
        chk("nobypass_in_ready", 32'(in_ready), 32'd0);
        cyc();
        chk("drain_head_22", 32'(a_data), 32'h22);
        chk("drain_in_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0; #1;
        chk("drain_head_33", 32'(a_data), 32'h33);
        chk("drain_valid_33", 32'(a_valid), 32'd1);
        cyc();
        chk("drain_empty", 32'(a_valid), 32'd0);

        // Simultaneous push and pop on the same buffer
        a_ready = 1'b0; in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h55;
        cyc();
        in_valid = 1'b0; #1;
        chk("pp_head_55", 32'(a_data), 32'h55);
        a_ready = 1'b1; in_valid = 1'b1; in_data = 8'h66; #1;
        chk("pp_in_ready", 32'(in_ready), 32'd1);
        cyc();
        in_valid = 1'b0; a_ready = 1'b0; #1;
        chk("pp_valid_66", 32'(a_valid), 32'd1);
        chk("pp_head_66", 32'(a_data), 32'h66);
        in_valid = 1'b1; in_data = 8'h77; #1;
        chk("pp_occ_one", 32'(in_ready), 32'd1);
        cyc();
        in_data = 8'h88; #1;
        chk("pp_occ_two", 32'(in_ready), 32'd0);

        // Fill b too, then reset mid-operation
        b_ready = 1'b0; in_sel = 1'b1; in_data = 8'h99;
        cyc();
        in_data = 8'hAA;
        cyc();
        in_data = 8'hBB; #1;
        chk("b_full_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0; #1;
        rst = 1'b1; #1;
        chk("midrst_a_valid", 32'(a_valid), 32'd0);
        chk("midrst_b_valid", 32'(b_valid), 32'd0);
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_a_data", 32'(a_data), 32'd0);
        chk("midrst_b_data", 32'(b_data), 32'd0);
        cyc();
        rst = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        cyc(); cyc();
        chk("postrst_a_valid", 32'(a_valid), 32'd0);
        chk("postrst_b_valid", 32'(b_valid), 32'd0);

        // Counters: 3 transfers on a, 2 on b
        in_valid = 1'b1; in_sel = 1'b0; in_data = 8'h01; cyc();
        in_data = 8'h02; cyc();
        in_data = 8'h03; cyc();
        in_sel = 1'b1; in_data = 8'h04; cyc();
        in_data = 8'h05; cyc();
        in_valid = 1'b0;
        cyc(); cyc();
        chk("cnt_a", 32'(a_cnt), CNT_EN ? 32'd3 : 32'd0);
        chk("cnt_b", 32'(b_cnt), CNT_EN ? 32'd2 : 32'd0);

        // Random traffic, checked by the scoreboard
        for (int i = 0; i < 300; i++) begin
            in_valid = 1'($urandom_range(0, 1));
            in_sel   = 1'($urandom_range(0, 1));
            in_data  = 8'($urandom);
            a_ready  = ($urandom_range(0, 3) != 0);
            b_ready  = ($urandom_range(0, 3) != 0);
            cyc();
        end
        in_valid = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
        repeat (4) cyc();
        chk("final_a_valid", 32'(a_valid), 32'd0);
        chk("final_b_valid", 32'(b_valid), 32'd0);
        chk("final_q_a", 32'(q_a.size()), 32'd0);
        chk("final_q_b", 32'(q_b.size()), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/demux_2_stream.md
DEMUX_2_STREAM -- requirements
Module: demux_2_stream

Interface
REQ-001 SHALL have parameter DATA_W, default 8, data width in bits of input and both outputs.
REQ-002 SHALL have parameter DEPTH, fixed at 2, entries per output buffer; other values are not supported.
REQ-003 SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous and active-high.
REQ-005 SHALL have port in_data  input  DATA_W  input payload.
REQ-006 SHALL have port in_sel  input  1  destination: 0 = channel a, 1 = channel b.
REQ-007 SHALL have port in_valid  input  1  input payload and sel are valid.
REQ-008 SHALL have port in_ready  output  1  the block accepts the input this cycle.
REQ-009 SHALL have port a_data  output  DATA_W  channel a head-of-buffer payload.
REQ-010 SHALL have port a_valid  output  1  channel a buffer is not empty.
REQ-011 SHALL have port a_ready  input  1  channel a sink accepts a_data.
REQ-012 SHALL have ports b_data, b_valid and b_ready, identical to the channel a ports, for channel b.
REQ-013 SHALL have port a_cnt  output  16  channel a completed-transfer count (see Configuration).
REQ-014 SHALL have port b_cnt  output  16  channel b completed-transfer count (see Configuration).

Function
REQ-015 SHALL define an input transfer as in_valid=1 and in_ready=1 on a rising clk edge; output transfers are x_valid=1 and x_ready=1.
REQ-016 SHALL drive in_ready combinationally as NOT full of the buffer selected by in_sel; it SHALL NOT depend on in_valid.
REQ-017 SHALL write an accepted in_data into the tail of the selected buffer only; the other buffer is unchanged.
REQ-018 SHALL present accepted data on x_data with x_valid=1 starting the cycle after acceptance (latency 1), never combinationally from in_data.
REQ-019 SHALL deliver each channel's data in acceptance order, with no loss and no duplication.
REQ-020 SHALL hold x_data and x_valid stable while x_valid=1 and x_ready=0.
REQ-021 SHALL, when a buffer is full, hold in_ready=0 for that sel even if a pop of that buffer occurs in the same cycle; no bypass.
REQ-022 SHALL, when a push and a pop hit the same non-full, non-empty buffer in one cycle, perform both and leave the occupancy unchanged.
REQ-023 SHALL let a pop on one channel and a push to the other channel occur in the same cycle, independently.
REQ-024 SHALL wrap read and write pointers modulo DEPTH and track occupancy 0..DEPTH per channel.
REQ-025 SHALL ignore x_ready while x_valid=0; an empty buffer SHALL NOT underflow.
REQ-026 SHALL sample in_sel only when in_valid=1; in_sel may change freely between transfers.

Reset
REQ-027 SHALL on rst=1 immediately clear both buffers (occupancy 0), pointers, and counters; a_valid=0, b_valid=0, a_cnt=0, b_cnt=0, and in_ready=1.
REQ-028 SHALL reset x_data to all zeros.
REQ-029 SHALL discard any buffered data on reset mid-operation and accept no transfer while rst=1.

Configuration
REQ-030 SHALL, with macro DEMUX_2_STREAM_CNT_EN defined, increment a_cnt and b_cnt by 1 on each output transfer of their channel, wrapping 16'hFFFF to 0.
REQ-031 SHALL, without DEMUX_2_STREAM_CNT_EN, keep the a_cnt and b_cnt ports but drive them constant 0, with no counter registers.

Verification
REQ-032 SHALL cover routing: after reset, send 8'hA5 sel=0 then 8'h3C sel=1 with both readys=1 -> a_data=A5 with a_valid one cycle after the first accept, then b_data=3C one cycle after the second accept; no cross-delivery.
REQ-033 SHALL cover backpressure/full: a_ready=0, send 11, 22, 33 to sel=0 -> 11 and 22 accepted, in_ready=0 for the third; raise a_ready -> 11 then 22 delivered, then 33 accepted.
REQ-034 SHALL cover channel independence: a full with a_ready=0, then send 44 with sel=1 -> in_ready=1, b_data=44 next cycle, and a_data holds 11.
REQ-035 SHALL cover simultaneous push/pop: a holding one entry 55, with a_ready=1, push 66 sel=0 -> 55 popped, 66 valid next cycle, occupancy stays 1.
REQ-036 SHALL cover reset mid-operation: both buffers full, assert rst between edges -> a_valid=b_valid=0 and in_ready=1 immediately; no old data reappears after release.
REQ-037 SHALL cover the counters with DEMUX_2_STREAM_CNT_EN: 3 a transfers and 2 b transfers -> a_cnt=3, b_cnt=2; without the macro both read 0 throughout.
